// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBITS data bits LSB first, optional even parity,
// then SB_TICK s_ticks of stop. Define UART_TX_PARITY_EN to add the parity bit.
module uart_tx #(
  parameter int DBITS   = 8,
  parameter int SB_TICK = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tx_start,
  input  logic             s_tick,
  input  logic [DBITS-1:0] tx_din,
  output logic             tx,
  output logic             tx_busy,
  output logic             tx_done_tick
);

  localparam int S_MAX = (SB_TICK > 16) ? SB_TICK : 16;
  localparam int SW    = $clog2(S_MAX);
  localparam int NW    = (DBITS > 1) ? $clog2(DBITS) : 1;

  localparam logic [SW-1:0] S_BIT_LAST  = SW'(15);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic parity_bit;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state;
  logic [SW-1:0]    s;
  logic [NW-1:0]    n;
  logic [DBITS-1:0] b;

  assign tx_busy = (state != IDLE);

  // NOTE: all state uses non-blocking assignments and the reset is sampled on
  // the clock edge, so every register (including the shift register) clears.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      tx           <= 1'b1;
      tx_done_tick <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit   <= 1'b0;
`endif
    end else begin
      tx_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (tx_start) begin
            b     <= tx_din;
            s     <= '0;
            tx    <= 1'b0;
            state <= START;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^tx_din;
`endif
          end
        end

        START: begin
          if (s_tick) begin
            if (s == S_BIT_LAST) begin
              s     <= '0;
              n     <= '0;
              tx    <= b[0];
              state <= DATA;
            end else begin
              s <= s + SW'(1);
            end
          end
        end

        DATA: begin
          if (s_tick) begin
            if (s == S_BIT_LAST) begin
              s <= '0;
              b <= b >> 1;
              if (n == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                tx    <= parity_bit;
                state <= PARITY;
`else
                tx    <= 1'b1;
                state <= STOP;
`endif
              end else begin
                n  <= n + NW'(1);
                tx <= b[1];
              end
            end else begin
              s <= s + SW'(1);
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (s_tick) begin
            if (s == S_BIT_LAST) begin
              s     <= '0;
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              s <= s + SW'(1);
            end
          end
        end
`endif

        STOP: begin
          // The done pulse is issued while still in STOP, so a tx_start seen
          // during the pulse is ignored and busy drops only afterwards.
          if (tx_done_tick) begin
            s     <= '0;
            state <= IDLE;
          end else if (s_tick) begin
            if (s == S_STOP_LAST) begin
              tx_done_tick <= 1'b1;
            end else begin
              s <= s + SW'(1);
            end
          end
        end

        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: scoreboard of sent bytes, mid-bit sampling
// of the serial line, frame-length, busy/done timing and reset-abort checks.
module tb_uart_tx;

  localparam int DBITS = 8;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick;
  logic       tx_start1, tx_start2;
  logic [7:0] din1, din2;
  logic       tx1, busy1, done1;
  logic       tx2, busy2, done2;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_cnt = 0;
  int done_total1 = 0;
  int done_total2 = 0;
  int t0;
  int d0;
  logic [7:0] exp_q[$];

  uart_tx #(.DBITS(DBITS), .SB_TICK(16)) dut1 (
    .clk(clk), .reset(reset), .tx_start(tx_start1), .s_tick(s_tick),
    .tx_din(din1), .tx(tx1), .tx_busy(busy1), .tx_done_tick(done1)
  );

  uart_tx #(.DBITS(DBITS), .SB_TICK(32)) dut2 (
    .clk(clk), .reset(reset), .tx_start(tx_start2), .s_tick(s_tick),
    .tx_din(din2), .tx(tx2), .tx_busy(busy2), .tx_done_tick(done2)
  );

  always #5 clk = ~clk;

  // Oversample strobe: one clk high every 5 clks.
  initial begin
    s_tick = 1'b0;
    forever begin
      repeat (4) @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (s_tick) tick_cnt <= tick_cnt + 1;
    if (done1)  done_total1 <= done_total1 + 1;
    if (done2)  done_total2 <= done_total2 + 1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_tx(input int w);
    return (w == 2) ? tx2 : tx1;
  endfunction
  function automatic logic get_busy(input int w);
    return (w == 2) ? busy2 : busy1;
  endfunction
  function automatic logic get_done(input int w);
    return (w == 2) ? done2 : done1;
  endfunction

  function automatic logic exp_bit(input logic [7:0] d, input int k, input int nb);
    if (k == 0) return 1'b0;
    if (k <= DBITS) return d[k-1];
    if (k == nb) return 1'b1;
    return ^d;
  endfunction

  // Drive a request; t0 is the tick count right after the accepting edge.
  task automatic send(input int w, input logic [7:0] d, input bit hold);
    @(negedge clk);
    if (w == 2) begin tx_start2 = 1'b1; din2 = d; end
    else        begin tx_start1 = 1'b1; din1 = d; end
    @(posedge clk); #1;
    t0 = tick_cnt;
    check($sformatf("busy_rise_dut%0d", w), get_busy(w), 1'b1);
    if (!hold) begin
      @(negedge clk);
      if (w == 2) tx_start2 = 1'b0; else tx_start1 = 1'b0;
    end
  endtask

  // Pops the expected byte and checks every bit at mid-period plus frame length.
  task automatic monitor(input int w, input int start_tick);
    logic [7:0] d;
    int sb, nb, len, el, last;
    bit found;
    sb = (w == 2) ? 32 : 16;
    nb = 1 + DBITS + P;
    len = 16 * nb + sb;
    last = -1;
    found = 1'b0;
    d = exp_q.pop_front();
    for (int c = 0; c < len * 6 + 20 && !found; c++) begin
      @(posedge clk); #1;
      el = tick_cnt - start_tick;
      if (get_done(w)) begin
        found = 1'b1;
        check($sformatf("frame_len_%0h", d), el, len);
        check($sformatf("busy_at_done_%0h", d), get_busy(w), 1'b1);
      end else if (el != last && el % 16 == 8 && el / 16 <= nb) begin
        check($sformatf("tx_%0h_bit%0d", d, el / 16), get_tx(w), exp_bit(d, el / 16, nb));
      end
      last = el;
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $error("FAIL done_timeout_%0h: observed no tx_done_tick expected one", d);
    end
  endtask

  task automatic after_frame(input int w);
    @(posedge clk); #1;
    check($sformatf("done_width_dut%0d", w), get_done(w), 1'b0);
    check($sformatf("busy_fall_dut%0d", w), get_busy(w), 1'b0);
    check($sformatf("tx_idle_dut%0d", w), get_tx(w), 1'b1);
  endtask

  task automatic wait_el(input int target);
    for (int c = 0; c < target * 6 + 20; c++) begin
      if (tick_cnt - t0 >= target) return;
      @(posedge clk); #1;
    end
    n_checks++;
    n_fail++;
    $error("FAIL wait_timeout: observed %0d ticks expected %0d", tick_cnt - t0, target);
  endtask

  initial begin
    reset = 1'b1;
    tx_start1 = 1'b0; tx_start2 = 1'b0;
    din1 = '0; din2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx1", tx1, 1'b1);
    check("reset_busy1", busy1, 1'b0);
    check("reset_done1", done1, 1'b0);
    check("reset_tx2", tx2, 1'b1);
    check("reset_busy2", busy2, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Basic frame.
    exp_q.push_back(8'hA5);
    send(1, 8'hA5, 1'b0);
    monitor(1, t0);
    after_frame(1);

    // Second request mid-frame is ignored; tx_din change has no effect.
    d0 = done_total1;
    exp_q.push_back(8'hA5);
    send(1, 8'hA5, 1'b0);
    fork
      monitor(1, t0);
      begin
        wait_el(40);
        @(negedge clk);
        tx_start1 = 1'b1;
        din1 = 8'h3C;
        @(negedge clk);
        tx_start1 = 1'b0;
      end
    join
    after_frame(1);
    repeat (200) @(posedge clk);
    #1;
    check("ignored_req_done_count", done_total1 - d0, 1);
    check("ignored_req_idle", busy1, 1'b0);

    // Back-to-back frames with tx_start held high.
    exp_q.push_back(8'h00);
    send(1, 8'h00, 1'b1);
    monitor(1, t0);
    exp_q.push_back(8'h00);
    @(posedge clk); #1;
    check("b2b_gap_busy", busy1, 1'b0);
    check("b2b_gap_tx", tx1, 1'b1);
    @(posedge clk); #1;
    check("b2b_restart_busy", busy1, 1'b1);
    t0 = tick_cnt;
    @(negedge clk);
    tx_start1 = 1'b0;
    @(posedge clk); #1;
    check("b2b_restart_tx", tx1, 1'b0);
    monitor(1, t0);
    after_frame(1);

    // Reset during DATA bit 3 of 8'hFF abandons the frame.
    send(1, 8'hFF, 1'b0);
    wait_el(72);
    check("pre_reset_bit3", tx1, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    d0 = done_total1;
    @(posedge clk); #1;
    check("midreset_tx", tx1, 1'b1);
    check("midreset_busy", busy1, 1'b0);
    check("midreset_done", done1, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    check("midreset_no_done", done_total1 - d0, 0);
    exp_q.push_back(8'h55);
    send(1, 8'h55, 1'b0);
    monitor(1, t0);
    after_frame(1);

    // Two stop bits on the second instance.
    exp_q.push_back(8'h81);
    send(2, 8'h81, 1'b0);
    monitor(2, t0);
    after_frame(2);
    check("dut2_done_count", done_total2, 1);

`ifdef UART_TX_PARITY_EN
    exp_q.push_back(8'h07);
    send(1, 8'h07, 1'b0);
    monitor(1, t0);
    after_frame(1);
    exp_q.push_back(8'h03);
    send(1, 8'h03, 1'b0);
    monitor(1, t0);
    after_frame(1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
